// File: rtl/ecc_10_pkg.sv
// rtl/ecc_10_pkg.sv - widths, error type and Hsiao column table for the 10-bit ECC
package ecc_10_pkg;

  localparam int ECC_DW = 10;
  localparam int ECC_PW = 5;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SBIT = 2'd1,
    ERR_DBIT = 2'd2
  } err_t;

  // Each data bit owns one distinct weight-3 column; parity bits own the unit columns.
  // All ten weight-3 patterns of a 5-bit syndrome are used, ascending by value.
  function automatic logic [ECC_PW-1:0] ecc_col(input int idx);
    logic [ECC_PW-1:0] col;
    case (idx)
      0:       col = 5'b00111;
      1:       col = 5'b01011;
      2:       col = 5'b01101;
      3:       col = 5'b01110;
      4:       col = 5'b10011;
      5:       col = 5'b10101;
      6:       col = 5'b10110;
      7:       col = 5'b11001;
      8:       col = 5'b11010;
      9:       col = 5'b11100;
      default: col = 5'b00000;
    endcase
    return col;
  endfunction

  // Parity that the write side stores alongside the data.
  function automatic logic [ECC_PW-1:0] ecc_parity(input logic [ECC_DW-1:0] data);
    logic [ECC_PW-1:0] par;
    par = '0;
    for (int i = 0; i < ECC_DW; i++) begin
      if (data[i]) par = par ^ ecc_col(i);
    end
    return par;
  endfunction

endpackage

// File: rtl/ecc_10_rd_pipe_if.sv
// rtl/ecc_10_rd_pipe_if.sv - RAM-read to FIFO-pop word stream bundle
interface ecc_10_rd_pipe_if
  import ecc_10_pkg::*;
#(
  parameter int AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ECC_DW-1:0] in_data;
  logic [ECC_PW-1:0] in_parity;
  logic [AW-1:0]     in_addr;
  logic              bypass;
  logic              out_valid;
  logic              out_ready;
  logic [ECC_DW-1:0] out_data;
  logic              out_sbit;
  logic              out_dbit;

  modport master (
    output in_valid, in_data, in_parity, in_addr, bypass, out_ready,
    input  in_ready, out_valid, out_data, out_sbit, out_dbit
  );

  modport slave (
    input  in_valid, in_data, in_parity, in_addr, bypass, out_ready,
    output in_ready, out_valid, out_data, out_sbit, out_dbit
  );
endinterface

// File: rtl/ecc_10_cal.sv
// rtl/ecc_10_cal.sv - combinational syndrome check and single-bit correction
module ecc_10_cal
  import ecc_10_pkg::*;
(
  input  logic [ECC_DW-1:0] data_in,
  input  logic [ECC_PW-1:0] parity_in,
  input  logic              bypass,
  output logic [ECC_DW-1:0] data_out,
  output err_t              err_type
);

  logic [ECC_PW-1:0] w_syn;

  assign w_syn = ecc_parity(data_in) ^ parity_in;

  // Zero syndrome is clean, a unit syndrome is a flipped parity bit, a data column
  // flips that data bit; anything else is uncorrectable and the data passes as stored.
  always_comb begin
    data_out = data_in;
    err_type = ERR_NONE;
    if (!bypass && (w_syn != '0)) begin
      if ($countones(w_syn) == 1) begin
        err_type = ERR_SBIT;
      end else begin
        err_type = ERR_DBIT;
        for (int i = 0; i < ECC_DW; i++) begin
          if (w_syn == ecc_col(i)) begin
            data_out[i] = ~data_in[i];
            err_type    = ERR_SBIT;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ecc_10_rd_pipe.sv
// rtl/ecc_10_rd_pipe.sv - two-stage read-side ECC pipeline with error counters and log
module ecc_10_rd_pipe
  import ecc_10_pkg::*;
#(
  parameter int AW = 4,
  parameter int CW = 8
)(
  input  logic          clk,
  input  logic          rst_n,
  ecc_10_rd_pipe_if.slave bus,
  input  logic          cnt_clr,
  output logic [CW-1:0] sbit_cnt,
  output logic [CW-1:0] dbit_cnt,
  output logic [AW-1:0] err_addr,
  output logic          err_addr_vld,
  output logic          err_is_dbit,
  output logic          err_irq
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic              r_s1_vld;
  logic              r_s1_byp;
  logic [ECC_DW-1:0] r_s1_data;
  logic [ECC_PW-1:0] r_s1_par;
  logic [AW-1:0]     r_s1_addr;

  logic              r_s2_vld;
  logic [ECC_DW-1:0] r_s2_data;
  logic              r_s2_sbit;
  logic              r_s2_dbit;

  logic [CW-1:0]     r_sbit_cnt;
  logic [CW-1:0]     r_dbit_cnt;
  logic [AW-1:0]     r_err_addr;
  logic              r_err_vld;
  logic              r_err_dbit;
  logic              r_irq;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_evt;
  logic              w_evt_sbit;
  logic              w_evt_dbit;
  logic              w_log_cap;
  logic [ECC_DW-1:0] w_cal_data;
  err_t              w_cal_err;

  ecc_10_cal u_cal (
    .data_in   (r_s1_data),
    .parity_in (r_s1_par),
    .bypass    (r_s1_byp),
    .data_out  (w_cal_data),
    .err_type  (w_cal_err)
  );

  assign w_s2_adv = !r_s2_vld || bus.out_ready;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;

  // A word is counted exactly once: at the moment it leaves S1 for S2.
  assign w_evt      = r_s1_vld && w_s2_adv;
  assign w_evt_sbit = w_evt && (w_cal_err == ERR_SBIT);
  assign w_evt_dbit = w_evt && (w_cal_err == ERR_DBIT);
  assign w_log_cap  = (w_evt_sbit || w_evt_dbit) &&
                      (!r_err_vld || (w_evt_dbit && !r_err_dbit));

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_vld;
  assign bus.out_data  = r_s2_data;
  assign bus.out_sbit  = r_s2_sbit;
  assign bus.out_dbit  = r_s2_dbit;

  assign sbit_cnt     = r_sbit_cnt;
  assign dbit_cnt     = r_dbit_cnt;
  assign err_addr     = r_err_addr;
  assign err_addr_vld = r_err_vld;
  assign err_is_dbit  = r_err_dbit;
  assign err_irq      = r_irq;

  // S1: capture the raw RAM word whenever the stage is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_byp  <= 1'b0;
      r_s1_data <= '0;
      r_s1_par  <= '0;
      r_s1_addr <= '0;
    end else if (w_s1_adv) begin
      r_s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_byp  <= bus.bypass;
        r_s1_data <= bus.in_data;
        r_s1_par  <= bus.in_parity;
        r_s1_addr <= bus.in_addr;
      end
    end
  end

  // S2: register the corrected word; held unchanged while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_sbit <= 1'b0;
      r_s2_dbit <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_cal_data;
        r_s2_sbit <= (w_cal_err == ERR_SBIT);
        r_s2_dbit <= (w_cal_err == ERR_DBIT);
      end
    end
  end

  // Saturating error counters; a clear beats a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbit_cnt <= '0;
      r_dbit_cnt <= '0;
    end else if (cnt_clr) begin
      r_sbit_cnt <= '0;
      r_dbit_cnt <= '0;
    end else begin
      if (w_evt_sbit && (r_sbit_cnt != CNT_MAX)) r_sbit_cnt <= r_sbit_cnt + CW'(1);
      if (w_evt_dbit && (r_dbit_cnt != CNT_MAX)) r_dbit_cnt <= r_dbit_cnt + CW'(1);
    end
  end

  // Error log keeps the first error, upgrading once if a dbit follows a logged sbit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_addr <= '0;
      r_err_vld  <= 1'b0;
      r_err_dbit <= 1'b0;
    end else if (cnt_clr) begin
      r_err_addr <= '0;
      r_err_vld  <= 1'b0;
      r_err_dbit <= 1'b0;
    end else if (w_log_cap) begin
      r_err_addr <= r_s1_addr;
      r_err_vld  <= 1'b1;
      r_err_dbit <= w_evt_dbit;
    end
  end

  // One-cycle interrupt per uncorrectable word, unaffected by counter clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= w_evt_dbit;
  end

endmodule

// File: tb/tb_ecc_10_rd_pipe.sv
// tb/tb_ecc_10_rd_pipe.sv - randomized self-checking bench for ecc_10_rd_pipe
module tb_ecc_10_rd_pipe;

  localparam int AW = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          cnt_clr;
  logic [CW-1:0] sbit_cnt;
  logic [CW-1:0] dbit_cnt;
  logic [AW-1:0] err_addr;
  logic          err_addr_vld;
  logic          err_is_dbit;
  logic          err_irq;

  ecc_10_rd_pipe_if #(.AW(AW)) bus ();

  ecc_10_rd_pipe #(.AW(AW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cnt_clr      (cnt_clr),
    .sbit_cnt     (sbit_cnt),
    .dbit_cnt     (dbit_cnt),
    .err_addr     (err_addr),
    .err_addr_vld (err_addr_vld),
    .err_is_dbit  (err_is_dbit),
    .err_irq      (err_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Code definition: data bit k uses the k-th smallest 5-bit value with three ones.
  function automatic logic [4:0] enc(input logic [9:0] d);
    logic [4:0] p;
    logic [4:0] col;
    int k;
    p = '0;
    k = 0;
    for (int v = 1; v < 32; v++) begin
      col = v[4:0];
      if ($countones(col) == 3) begin
        if (d[k]) p = p ^ col;
        k++;
      end
    end
    return p;
  endfunction

  // Minimum-distance decode: find a codeword within one flip of the received word.
  function automatic void classify(input logic [9:0] d, input logic [4:0] p,
                                   output logic [9:0] od, output logic sb, output logic db);
    logic [9:0] t;
    od = d; sb = 1'b0; db = 1'b0;
    if (enc(d) != p) begin
      db = 1'b1;
      for (int i = 0; i < 10; i++) begin
        t = d;
        t[i] = ~t[i];
        if (enc(t) == p) begin od = t; sb = 1'b1; db = 1'b0; end
      end
      for (int j = 0; j < 5; j++) begin
        if ((enc(d) ^ p) == (5'd1 << j)) begin sb = 1'b1; db = 1'b0; end
      end
    end
  endfunction

  typedef struct {
    logic [9:0]    d;
    logic          sb;
    logic          db;
    logic [AW-1:0] a;
  } ent_t;

  ent_t q[$];
  bit   front_in_s2;
  int   m_scnt, m_dcnt;
  logic m_lv, m_ld, m_irq;
  logic [AW-1:0] m_la;
  int   n_pop, irq_seen;

  // Reference: words flow in order through a two-deep queue; outputs compared every cycle.
  always @(negedge clk) begin
    logic exp_v, pop, ev_s, ev_d;
    logic [AW-1:0] ev_a;
    int ev_idx;
    ent_t e;
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sbit_cnt", sbit_cnt, 0);
      chk("rst_dbit_cnt", dbit_cnt, 0);
      chk("rst_err_vld", err_addr_vld, 0);
      chk("rst_err_addr", err_addr, 0);
      chk("rst_irq", err_irq, 0);
      q.delete();
      front_in_s2 = 0;
      m_scnt = 0; m_dcnt = 0; m_lv = 0; m_ld = 0; m_la = '0; m_irq = 0;
    end else begin
      exp_v = (q.size() > 0) && front_in_s2;
      chk("out_valid", bus.out_valid, exp_v);
      if (exp_v) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_sbit", bus.out_sbit, q[0].sb);
        chk("out_dbit", bus.out_dbit, q[0].db);
      end
      chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
      chk("sbit_cnt", sbit_cnt, m_scnt);
      chk("dbit_cnt", dbit_cnt, m_dcnt);
      chk("err_addr_vld", err_addr_vld, m_lv);
      chk("err_is_dbit", err_is_dbit, m_ld);
      chk("err_addr", err_addr, m_la);
      chk("err_irq", err_irq, m_irq);
      if (err_irq) irq_seen++;

      pop = exp_v && bus.out_ready;
      ev_idx = -1;
      if (q.size() > 0 && !front_in_s2) ev_idx = 0;
      else if (pop && q.size() > 1)     ev_idx = 1;
      ev_s = 0; ev_d = 0; ev_a = '0;
      if (ev_idx >= 0) begin
        ev_s = q[ev_idx].sb; ev_d = q[ev_idx].db; ev_a = q[ev_idx].a;
        front_in_s2 = 1;
      end else if (pop) begin
        front_in_s2 = 0;
      end

      if (cnt_clr) begin
        m_scnt = 0; m_dcnt = 0; m_lv = 0; m_ld = 0; m_la = '0;
      end else begin
        if (ev_s && m_scnt < CMAX) m_scnt++;
        if (ev_d && m_dcnt < CMAX) m_dcnt++;
        if ((ev_s || ev_d) && (!m_lv || (ev_d && !m_ld))) begin
          m_lv = 1; m_ld = ev_d; m_la = ev_a;
        end
      end
      m_irq = ev_d;

      if (pop) begin void'(q.pop_front()); n_pop++; end
      if (bus.in_valid && bus.in_ready) begin
        classify(bus.in_data, bus.in_parity, e.d, e.sb, e.db);
        if (bus.bypass) begin e.d = bus.in_data; e.sb = 0; e.db = 0; end
        e.a = bus.in_addr;
        q.push_back(e);
      end
    end
  end

  // out_ready patterns: 0 held high, 1 toggling, 2 random, 3 held low.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one word and hold it until accepted; entered and left at posedge+1.
  task automatic send(input logic [9:0] d, input logic [4:0] p, input logic [AW-1:0] a, input logic b);
    bit ok;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_parity = p; bus.in_addr = a; bus.bypass = b;
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for addr %0h", a);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic gen_word(output logic [9:0] d, output logic [4:0] p);
    logic [14:0] cw;
    int nf, b1, b2;
    d = 10'($urandom);
    p = enc(d);
    cw = {p, d};
    nf = $urandom_range(0, 2);
    b1 = $urandom_range(0, 14);
    if (nf >= 1) cw[b1] = ~cw[b1];
    if (nf == 2) begin
      b2 = $urandom_range(0, 13);
      if (b2 >= b1) b2++;
      cw[b2] = ~cw[b2];
    end
    d = cw[9:0];
    p = cw[14:10];
  endtask

  task automatic random_burst(input int n);
    logic [9:0] d;
    logic [4:0] p;
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2) == 0 ? 1 : 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      gen_word(d, p);
      send(d, p, AW'($urandom), ($urandom_range(0, 7) == 0));
    end
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic [9:0] od;
    logic sb, db;
    int base;
    rst_n = 1'b0; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_parity = '0; bus.in_addr = '0;
    bus.bypass = 1'b0; bus.out_ready = 1'b1;
    n_pop = 0; irq_seen = 0;

    // Pin the reference decoder on hand-worked words.
    chk("model_enc1", enc(10'h001), 5'b00111);
    classify(10'h001, 5'h00, od, sb, db);
    chk("model_t2", {od, sb, db}, {10'h000, 1'b1, 1'b0});
    classify(10'h003, 5'h00, od, sb, db);
    chk("model_t3", {od, sb, db}, {10'h003, 1'b0, 1'b1});
    classify(10'h000, 5'h01, od, sb, db);
    chk("model_t4", {od, sb, db}, {10'h000, 1'b1, 1'b0});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // T1 clean word
    send(10'h000, 5'h00, 4'd1, 1'b0);
    idle(3);
    chk("t1_sbit_cnt", sbit_cnt, 0);
    chk("t1_dbit_cnt", dbit_cnt, 0);

    // T2 single data-bit error
    send(10'h001, 5'h00, 4'd3, 1'b0);
    idle(3);
    chk("t2_sbit_cnt", sbit_cnt, 1);
    chk("t2_err_addr", {err_addr_vld, err_is_dbit, err_addr}, {1'b1, 1'b0, 4'd3});

    // T3 double error upgrades the log and pulses the irq once
    base = irq_seen;
    send(10'h003, 5'h00, 4'd5, 1'b0);
    idle(3);
    chk("t3_dbit_cnt", dbit_cnt, 1);
    chk("t3_err_addr", {err_addr_vld, err_is_dbit, err_addr}, {1'b1, 1'b1, 4'd5});
    chk("t3_irq_pulses", irq_seen - base, 1);

    // T4 parity-only error, then the same word bypassed
    send(10'h000, 5'h01, 4'd7, 1'b0);
    idle(3);
    chk("t4_sbit_cnt", sbit_cnt, 2);
    chk("t4_log_hold", {err_is_dbit, err_addr}, {1'b1, 4'd5});
    send(10'h000, 5'h01, 4'd7, 1'b1);
    idle(3);
    chk("t4_bypass_cnt", sbit_cnt, 2);

    // T5 eight clean words under toggling backpressure
    base = n_pop;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      od = 10'($urandom);
      send(od, enc(od), AW'(i), 1'b0);
    end
    rdy_mode = 0;
    idle(6);
    chk("t5_delivered", n_pop - base, 8);

    // T6 saturation, clear racing events, then mid-burst reset
    for (int i = 0; i < 5; i++) send(10'h200, 5'h00, 4'd9, 1'b0);
    idle(3);
    chk("t6_saturate", sbit_cnt, CMAX);
    cnt_clr = 1'b1;
    send(10'h004, 5'h00, 4'd2, 1'b0);
    send(10'h003, 5'h00, 4'd2, 1'b0);
    idle(3);
    cnt_clr = 1'b0;
    idle(1);
    chk("t6_clear", {sbit_cnt, dbit_cnt, err_addr_vld}, 0);

    rdy_mode = 2;
    random_burst(300);

    rdy_mode = 0;
    idle(4);
    rdy_mode = 3;
    idle(1);
    send(10'h155, enc(10'h155), 4'd1, 1'b0);
    send(10'h0aa, enc(10'h0aa), 4'd2, 1'b0);
    chk("pre_rst_full", {bus.out_valid, bus.in_ready}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    idle(2);
    rst_n = 1'b1;
    rdy_mode = 2;
    random_burst(60);
    rdy_mode = 0;
    idle(6);
    chk("drain_empty", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
